// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locking write-port arbiter with write pointer and full generation
module fifo_wr_arbiter #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4,
    parameter int NREQ     = 4
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_last,
    input  logic [NREQ*DATASIZE-1:0]   req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic [ADDRSIZE:0]          rd_ptr_gray_sync,
    output logic                       wr_en,
    output logic [ADDRSIZE-1:0]        wr_addr,
    output logic [DATASIZE-1:0]        wdata,
    output logic                       wr_full,
    output logic [ADDRSIZE:0]          wr_ptr_gray,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       locked
);
    localparam int GW = $clog2(NREQ);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t            state_q, state_d;
    logic [GW-1:0]     owner_q, owner_d, rr_q, rr_d, grant_q, grant_d, cand, idx, g;
    logic [ADDRSIZE:0] wbin_q, wbin_d, gray_q, gray_d;
    logic              full_q, full_d, found, accept;
    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = GW'((int'(rr_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
    end
    assign g         = (state_q == LOCK) ? owner_q : cand;
    assign req_ready = (!wr_rst && !full_q && (state_q == LOCK || found)) ? NREQ'(1) << g : '0;
    assign accept    = req_valid[g] & req_ready[g];
    assign wr_en     = accept;
    assign wdata     = req_data[g*DATASIZE +: DATASIZE];
    assign wr_addr   = wbin_q[ADDRSIZE-1:0];
    assign wr_full   = full_q;
    assign wr_ptr_gray = gray_q;
    assign grant_id  = grant_q;
    assign locked    = (state_q == LOCK);
    // Full compares the post-accept pointer so a same-cycle read advance and write both count
    always_comb begin
        wbin_d  = wbin_q + (ADDRSIZE+1)'(accept);
        gray_d  = wbin_d ^ (wbin_d >> 1);
        full_d  = gray_d == {~rd_ptr_gray_sync[ADDRSIZE:ADDRSIZE-1], rd_ptr_gray_sync[ADDRSIZE-2:0]};
        state_d = accept ? (req_last[g] ? IDLE : LOCK) : state_q;
        owner_d = accept ? g : owner_q;
        grant_d = accept ? g : grant_q;
        rr_d    = (accept && req_last[g]) ? ((int'(g) == NREQ-1) ? '0 : g + 1'b1) : rr_q;
    end
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            wbin_q  <= '0;
            gray_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            wbin_q  <= wbin_d;
            gray_q  <= gray_d;
            full_q  <= full_d;
        end
    end
    for (genvar i = 0; i < NREQ; i++) begin : g_hold
        a_hold: assert property (@(posedge wr_clk) disable iff (wr_rst)
            req_valid[i] && !req_ready[i] |=> req_valid[i] && $stable(req_last[i])
                && $stable(req_data[i*DATASIZE +: DATASIZE]));
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: occupancy-based reference model plus directed scenarios with literal expectations
module tb_fifo_wr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] valid = 4'b0, last = 4'b0;
    logic [7:0] dat [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
    logic [31:0] req_data;
    logic [3:0] ready;
    logic [4:0] rq, rq_man = 5'b0, d1 = 5'b0, d2 = 5'b0;
    logic       track = 1'b0;
    logic       wr_en, wr_full, locked;
    logic [3:0] wr_addr;
    logic [7:0] wdata;
    logic [4:0] wr_ptr_gray;
    logic [1:0] grant_id;
    int pass = 0, total = 0;

    fifo_wr_arbiter #(.DATASIZE(8), .ADDRSIZE(4), .NREQ(4)) dut (
        .wr_clk(clk), .wr_rst(rst), .req_valid(valid), .req_last(last), .req_data(req_data),
        .req_ready(ready), .rd_ptr_gray_sync(rq), .wr_en(wr_en), .wr_addr(wr_addr), .wdata(wdata),
        .wr_full(wr_full), .wr_ptr_gray(wr_ptr_gray), .grant_id(grant_id), .locked(locked)
    );

    always #5 clk = ~clk;
    assign req_data = {dat[3], dat[2], dat[1], dat[0]};
    assign rq = track ? d2 : rq_man;

    // read side that instantly drains: write Gray pointer seen two cycles late
    always begin
        @(posedge clk);
        #1;
        d2 = d1;
        d1 = wr_ptr_gray;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int g2b(input logic [4:0] gv);
        int b = 0;
        for (int i = 4; i >= 0; i--) b = b | ((((b >> (i + 1)) & 1) ^ int'(gv[i])) << i);
        return b;
    endfunction

    // model: state after the coming edge is computed at each negedge from the stable inputs
    int m_wbin, m_rr, m_own, m_gid, mg;
    bit m_full, minit = 0, have_prev = 0, macc;
    logic [3:0] er;
    logic [1:0] ix;
    logic [4:0] prev_gray;
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", int'(ready), 0);
            chk("rst_wr_en", int'(wr_en), 0);
            m_wbin = 0; m_rr = 0; m_own = -1; m_gid = 0; m_full = 0;
            minit = 1; have_prev = 0;
        end else if (minit) begin
            mg = m_own;
            for (int k = 0; k < 4; k++) begin
                ix = 2'((m_rr + k) % 4);
                if (mg < 0 && valid[ix]) mg = int'(ix);
            end
            er = (!m_full && mg >= 0) ? 4'(1 << mg) : 4'b0;
            macc = (er & valid) != 4'b0;
            chk("m_ready", int'(ready), int'(er));
            chk("m_wr_en", int'(wr_en), int'(macc));
            chk("m_addr", int'(wr_addr), m_wbin % 16);
            chk("m_full", int'(wr_full), int'(m_full));
            chk("m_gray", int'(wr_ptr_gray), m_wbin ^ (m_wbin >> 1));
            chk("m_grant", int'(grant_id), m_gid);
            chk("m_locked", int'(locked), int'(m_own >= 0));
            if (macc) chk("m_wdata", int'(wdata), int'(dat[mg]));
            if (have_prev && wr_ptr_gray != prev_gray)
                chk("gray_step", $countones(wr_ptr_gray ^ prev_gray), 1);
            prev_gray = wr_ptr_gray;
            have_prev = 1;
            if (macc) begin
                m_wbin = (m_wbin + 1) % 32;
                m_gid = mg;
                if (last[mg]) begin
                    m_own = -1;
                    m_rr = (mg + 1) % 4;
                end else m_own = mg;
            end
            m_full = ((m_wbin - g2b(rq) + 32) % 32) == 16;
        end
    end

    task automatic do_reset();
        rst = 1'b1; valid = 4'b0; last = 4'b0; track = 1'b0; rq_man = 5'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        track = 1'b1;
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        int r = -1;
        for (int k = 0; k < 4; k++) if (v[k]) r = k;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, cyc, k1, cnt, la;
        bit acc;
        int seq [8];
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        // fill 16 words with the read pointer parked at 0
        valid = 4'b0001; last = 4'b0001; dat[0] = 8'hA0; n = 0; la = -1;
        repeat (20) begin
            @(negedge clk);
            acc = ready[0] && valid[0];
            if (acc) la = int'(wr_addr);
            @(posedge clk);
            #1;
            if (acc) begin n++; dat[0] = dat[0] + 8'h1; end
        end
        chk("fill_writes", n, 16);
        chk("fill_last_addr", la, 15);
        @(negedge clk);
        chk("full_set", int'(wr_full), 1);
        chk("full_ready0", int'(ready), 0);
        // one read-pointer step frees exactly one slot
        @(posedge clk);
        #1 rq_man = 5'b00001;
        @(negedge clk);
        chk("step_full_hold", int'(wr_full), 1);
        @(negedge clk);
        chk("step_full_clear", int'(wr_full), 0);
        chk("step_wr_en", int'(wr_en), 1);
        chk("step_wdata", int'(wdata), 8'hB0);
        chk("step_addr", int'(wr_addr), 0);
        @(posedge clk);
        #1 dat[0] = 8'hB1;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            n += int'(wr_en);
            @(posedge clk);
            #1;
        end
        chk("step_extra_writes", n, 0);
        chk("step_full_again", int'(wr_full), 1);
        // all four single-word requesters: strict rotation
        do_reset();
        valid = 4'b1111; last = 4'b1111;
        dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'h32; dat[3] = 8'h43;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_wr_en", int'(wr_en), 1);
            chk("rr_grant", oh_idx(ready), i % 4);
            @(posedge clk);
            #1;
        end
        // req1 3-word burst locks out req2
        do_reset();
        valid = 4'b0110; last = 4'b0100; dat[1] = 8'h31; dat[2] = 8'h77; k1 = 0; cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("burst_lock_ready", int'(ready), 4'b0010);
                chk("burst_locked", int'(locked), 1);
            end
            acc = wr_en;
            if (acc) begin seq[cnt] = oh_idx(ready); cnt++; end
            @(posedge clk);
            #1;
            if (acc && seq[cnt-1] == 1) begin
                k1++;
                dat[1] = dat[1] + 8'h1;
                if (k1 == 2) last[1] = 1'b1;
                if (k1 == 3) valid[1] = 1'b0;
            end
        end
        chk("burst_count", cnt, 6);
        for (int i = 0; i < 6; i++) chk("burst_order", seq[i], (i < 3) ? 1 : 2);
        // 40 words with a tracking read side: address and pointer wrap without stall
        do_reset();
        valid = 4'b0001; last = 4'b0001; dat[0] = 8'h0; n = 0; cyc = 0;
        while (n < 40 && cyc < 200) begin
            @(negedge clk);
            acc = ready[0] && valid[0];
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                n++;
                dat[0] = dat[0] + 8'h1;
                if (n == 40) valid = 4'b0;
            end
        end
        chk("wrap_writes", n, 40);
        chk("wrap_no_stall", cyc, 40);
        @(negedge clk);
        chk("wrap_addr", int'(wr_addr), 8);
        chk("wrap_gray", int'(wr_ptr_gray), 5'b01100);
        chk("wrap_full", int'(wr_full), 0);
        // reset in the middle of a req2 burst
        do_reset();
        valid = 4'b0100; last = 4'b0000; dat[2] = 8'h55;
        @(negedge clk);
        chk("mid_ready2", int'(ready), 4'b0100);
        @(posedge clk);
        #1 dat[2] = 8'h56;
        valid = 4'b0101; dat[0] = 8'h99; last[0] = 1'b1;
        @(negedge clk);
        chk("mid_locked", int'(locked), 1);
        chk("mid_ready_owner", int'(ready), 4'b0100);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", int'(ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_locked_clr", int'(locked), 0);
        chk("mid_gray0", int'(wr_ptr_gray), 0);
        chk("mid_addr0", int'(wr_addr), 0);
        chk("mid_grant0", int'(grant_id), 0);
        chk("mid_req0_first", int'(ready), 4'b0001);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
